interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
Interrupt front end for the program counter stage. It synchronises and edge-detects two external requests and holds them pending under a global enable. At FETCH boundaries it drives the PC's PC_LD_INT0X, PC_LD_INT1X and PC_NEXTX controls to enter vectors INTV0/INTV1 or to return through the saved INTR0/INTR1 registers. It tracks one level of nesting: INT0 may preempt INT1, never the reverse.

Parameters:
SYNC_STAGES, 2, flops in each request synchroniser (minimum 2).

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
FETCH  in  1  fetch-phase strobe, the same signal the PC sees
INT0_REQ  in  1  async external request, high priority, rising-edge sensitive
INT1_REQ  in  1  async external request, low priority, rising-edge sensitive
EI  in  1  decode strobe, enable interrupts
DI  in  1  decode strobe, disable interrupts
RETI  in  1  decode strobe, return-from-interrupt instruction
PC_LD_INT0X  out  1  save return address into INTR0 (combinational, valid only with FETCH)
PC_LD_INT1X  out  1  save return address into INTR1 (combinational, valid only with FETCH)
PC_NEXTX  out  3  PC next-address select
INT_LEVEL  out  2  0=idle, 1=in INT1, 2=in INT0, 3=INT0 nested over INT1
IE  out  1  global interrupt enable flag
INT0_PENDING  out  1  latched INT0 request
INT1_PENDING  out  1  latched INT1 request

Behaviour:
- Reset (synchronous, RESET high at posedge): synchronisers 0, edge-history 0, pending flags 0, IE=0, reti_pend=0, state IDLE. Outputs with FETCH low are PC_LD_*=0 and PC_NEXTX=NEXT. Reset mid-handler discards nesting and pending requests.
- Sync and edge: a request is sampled through SYNC_STAGES flops plus one history flop. The rising edge sets the pending flag. The flag is visible SYNC_STAGES+1 clocks after the first CLK at which the raw input is high. Multiple edges while pending collapse into one request.
- IE: set by EI, cleared by DI; both at once → DI wins. Interrupt entry does not alter IE.
- RETI sets the reti_pend register. It is consumed at the next FETCH cycle.
- Four states encode the nest stack: IDLE, L1, L0, L01. INT_LEVEL mirrors the state.
- Arbitration applies only in cycles with FETCH high, one action per FETCH, in this priority order:
  1. reti_pend: L01→L1 with PC_NEXTX=INTR0; L0→IDLE with INTR0; L1→IDLE with INTR1; IDLE → ignored, PC_NEXTX=NEXT. Clear reti_pend. No interrupt is taken in this FETCH; a pending one is taken at the next FETCH.
  2. take0 = IE & INT0_PENDING & state∈{IDLE,L1}: assert PC_LD_INT0X, PC_NEXTX=INTV0. Clear INT0_PENDING. IDLE→L0, L1→L01.
  3. take1 = IE & INT1_PENDING & state==IDLE: assert PC_LD_INT1X, PC_NEXTX=INTV1. Clear INT1_PENDING. IDLE→L1.
  4. Otherwise PC_NEXTX=NEXT.
- At most one of PC_LD_INT0X/PC_LD_INT1X is high; both are 0 when FETCH=0. PC_NEXTX=NEXT whenever FETCH=0.
- A new edge in the same cycle its pending flag is cleared by a take: set wins, and the request stays pending.
- A request pending at its own active level, or INT1 while in L0/L01, stays pending until the state allows it.
- State, pending, IE and reti_pend are all registered. Arbitration outputs are combinational from registers plus FETCH, so there is zero latency into the PC within the FETCH cycle.

Decomposition:
- PC_NEXTX codes (NEXT=0, INTV0=1, INTV1=2, INTR0=3, INTR1=4), the INTV0/INTV1 addresses and the state/INT_LEVEL encodings live in the shared constants include used by the PC.
- One sub-module, int_sync_edge: parameterised synchroniser plus rising-edge detector, instantiated twice.

Test Plan:
- Reset, then INT0_REQ pulse with IE=0 → INT0_PENDING=1 after 3 clocks; FETCH gives PC_NEXTX=NEXT and no PC_LD_*. After EI, next FETCH → PC_LD_INT0X=1, PC_NEXTX=1, INT_LEVEL=2, pending cleared.
- IE=1, INT0 and INT1 edges in the same clock → first FETCH takes INT0 (PC_NEXTX=1). INT1 stays pending while INT_LEVEL=2. RETI then FETCH → PC_NEXTX=3, INT_LEVEL=0. Following FETCH → PC_NEXTX=2, PC_LD_INT1X=1.
- In INT1 (level 1), INT0 edge → FETCH gives PC_NEXTX=1, level 3. RETI+FETCH → PC_NEXTX=3, level 1. RETI+FETCH → PC_NEXTX=4, level 0.
- RETI pending and INT1 pending at the same FETCH in L1 → return wins (PC_NEXTX=4); INT1 taken at the next FETCH.
- EI and DI in the same cycle → IE=0. RETI in IDLE → PC_NEXTX=NEXT, state unchanged.
- RESET asserted in L01 with both requests pending → after one clock INT_LEVEL=0, pendings=0, IE=0, PC_NEXTX=0.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg: PC next-address select codes, vector addresses and nest-state encoding
package interrupt_sequencer_pkg;
    typedef enum logic [2:0] {
        NEXT  = 3'd0,
        INTV0 = 3'd1,
        INTV1 = 3'd2,
        INTR0 = 3'd3,
        INTR1 = 3'd4
    } pc_next_t;
    localparam logic [15:0] INTV0_ADDR = 16'h0004;
    localparam logic [15:0] INTV1_ADDR = 16'h0008;
    // encoding doubles as INT_LEVEL: bit1 = in INT0, bit0 = in INT1
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L0   = 2'd2,
        L01  = 2'd3
    } int_state_t;
endpackage

// File: rtl/interrupt_sequencer_int_sync_edge.sv
// int_sync_edge: multi-flop synchroniser followed by a rising-edge detector
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic req,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], req};
            hist <= sync[SYNC_STAGES-1];
        end
    end
    assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: request latching, enable and one-level nesting control for the PC stage
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FETCH,
    input  logic       INT0_REQ,
    input  logic       INT1_REQ,
    input  logic       EI,
    input  logic       DI,
    input  logic       RETI,
    output logic       PC_LD_INT0X,
    output logic       PC_LD_INT1X,
    output logic [2:0] PC_NEXTX,
    output logic [1:0] INT_LEVEL,
    output logic       IE,
    output logic       INT0_PENDING,
    output logic       INT1_PENDING
);
    int_state_t state, state_nxt;
    pc_next_t   nxt;
    logic       rise0, rise1, ie_q, reti_pend, pend0, pend1, ret, take0, take1;

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
        .CLK(CLK), .RESET(RESET), .req(INT0_REQ), .rise(rise0)
    );
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .CLK(CLK), .RESET(RESET), .req(INT1_REQ), .rise(rise1)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            ie_q      <= 1'b0;
            reti_pend <= 1'b0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ie_q      <= DI ? 1'b0 : (EI ? 1'b1 : ie_q);
            reti_pend <= RETI | (reti_pend & ~FETCH);
            // a fresh edge beats the clear from a take in the same cycle
            pend0     <= rise0 | (pend0 & ~take0);
            pend1     <= rise1 | (pend1 & ~take1);
        end
    end

    // return has priority; otherwise INT0 may preempt INT1, never the reverse
    always_comb begin
        ret       = FETCH & reti_pend;
        take0     = FETCH & ~reti_pend & ie_q & pend0 & (state == IDLE || state == L1);
        take1     = FETCH & ~reti_pend & ~take0 & ie_q & pend1 & (state == IDLE);
        state_nxt = ret   ? ((state == L01) ? L1 : IDLE) :
                    take0 ? ((state == L1) ? L01 : L0) :
                    take1 ? L1 : state;
        nxt       = ret   ? ((state == L1) ? INTR1 : (state == IDLE) ? NEXT : INTR0) :
                    take0 ? INTV0 :
                    take1 ? INTV1 : NEXT;
    end

    assign PC_LD_INT0X  = take0;
    assign PC_LD_INT1X  = take1;
    assign PC_NEXTX     = nxt;
    assign INT_LEVEL    = state;
    assign IE           = ie_q;
    assign INT0_PENDING = pend0;
    assign INT1_PENDING = pend1;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed test-plan checks plus randomized run against a stack-based reference model
module tb_interrupt_sequencer;
    localparam int S = 2;
    logic       CLK = 1'b0, RESET = 1'b1, FETCH = 1'b0, INT0_REQ = 1'b0, INT1_REQ = 1'b0;
    logic       EI = 1'b0, DI = 1'b0, RETI = 1'b0;
    logic       PC_LD_INT0X, PC_LD_INT1X, IE, INT0_PENDING, INT1_PENDING;
    logic [2:0] PC_NEXTX;
    logic [1:0] INT_LEVEL;
    int         checks = 0, failures = 0;
    bit         mon_on = 0;

    interrupt_sequencer #(.SYNC_STAGES(S)) dut (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .INT0_REQ(INT0_REQ), .INT1_REQ(INT1_REQ),
        .EI(EI), .DI(DI), .RETI(RETI), .PC_LD_INT0X(PC_LD_INT0X), .PC_LD_INT1X(PC_LD_INT1X),
        .PC_NEXTX(PC_NEXTX), .INT_LEVEL(INT_LEVEL), .IE(IE),
        .INT0_PENDING(INT0_PENDING), .INT1_PENDING(INT1_PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: raw-sample history, pending bits, enable, and an explicit stack of active handlers
    bit [S:0] q0 = '0, q1 = '0;
    bit       m_p0 = 0, m_p1 = 0, m_ie = 0, m_reti = 0;
    int       stk[$];

    function automatic int level();
        int l = 0;
        foreach (stk[i]) l += (stk[i] == 0) ? 2 : 1;
        return l;
    endfunction

    function automatic bit in0();
        foreach (stk[i]) if (stk[i] == 0) return 1;
        return 0;
    endfunction

    initial forever begin
        bit r0, r1, ret, t0, t1;
        int top, e_nx;
        @(negedge CLK);
        r0  = q0[S-1] & ~q0[S];
        r1  = q1[S-1] & ~q1[S];
        top = stk.size() ? stk[$] : -1;
        ret = FETCH & m_reti;
        t0  = FETCH & ~m_reti & m_ie & m_p0 & ~in0();
        t1  = FETCH & ~m_reti & ~t0 & m_ie & m_p1 & (stk.size() == 0);
        e_nx = ret ? ((top < 0) ? 0 : (top == 0) ? 3 : 4) : t0 ? 1 : t1 ? 2 : 0;
        if (mon_on) begin
            chk("m_nextx", int'(PC_NEXTX), e_nx);
            chk("m_ld0", int'(PC_LD_INT0X), int'(t0));
            chk("m_ld1", int'(PC_LD_INT1X), int'(t1));
            chk("m_level", int'(INT_LEVEL), level());
            chk("m_ie", int'(IE), int'(m_ie));
            chk("m_pend0", int'(INT0_PENDING), int'(m_p0));
            chk("m_pend1", int'(INT1_PENDING), int'(m_p1));
        end
        if (RESET) begin
            q0 = '0; q1 = '0; m_p0 = 0; m_p1 = 0; m_ie = 0; m_reti = 0;
            stk.delete();
        end else begin
            q0 = {q0[S-1:0], INT0_REQ};
            q1 = {q1[S-1:0], INT1_REQ};
            m_p0 = r0 | (m_p0 & ~t0);
            m_p1 = r1 | (m_p1 & ~t1);
            m_ie = DI ? 0 : EI ? 1 : m_ie;
            m_reti = RETI | (m_reti & ~FETCH);
            if (ret && stk.size()) void'(stk.pop_back());
            if (t0) stk.push_back(0);
            if (t1) stk.push_back(1);
        end
    end

    // v = {RESET, FETCH, EI, DI, RETI, INT0_REQ, INT1_REQ}; returns at the following negedge
    task automatic tick(input logic [6:0] v);
        @(posedge CLK);
        #1;
        {RESET, FETCH, EI, DI, RETI, INT0_REQ, INT1_REQ} = v;
        @(negedge CLK);
    endtask

    task automatic idle3();
        repeat (3) tick(7'b0000000);
    endtask

    initial begin
        logic [6:0] v;
        bit ra = 0, rb = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        mon_on = 1;
        @(negedge CLK);
        chk("rst_level", int'(INT_LEVEL), 0);
        chk("rst_ie", int'(IE), 0);
        // INT0 with IE=0: pending after 3 clocks, not taken until EI
        tick(7'b0000010);
        tick(7'b0000000);
        tick(7'b0000000);
        chk("p0_not_yet", int'(INT0_PENDING), 0);
        tick(7'b0000000);
        chk("p0_after3", int'(INT0_PENDING), 1);
        tick(7'b0100000);
        chk("ie0_nextx", int'(PC_NEXTX), 0);
        chk("ie0_ld0", int'(PC_LD_INT0X), 0);
        tick(7'b0010000);
        tick(7'b0100000);
        chk("take0_ld0", int'(PC_LD_INT0X), 1);
        chk("take0_nextx", int'(PC_NEXTX), 1);
        tick(7'b0000000);
        chk("take0_level", int'(INT_LEVEL), 2);
        chk("take0_clr", int'(INT0_PENDING), 0);
        tick(7'b0000100);
        tick(7'b0100000);
        chk("ret_l0_nextx", int'(PC_NEXTX), 3);
        // simultaneous edges: INT0 first, INT1 waits for the return
        tick(7'b0000011);
        idle3();
        tick(7'b0100000);
        chk("both_nextx", int'(PC_NEXTX), 1);
        tick(7'b0100000);
        chk("hold1_nextx", int'(PC_NEXTX), 0);
        chk("hold1_level", int'(INT_LEVEL), 2);
        chk("hold1_pend", int'(INT1_PENDING), 1);
        tick(7'b0000100);
        tick(7'b0100000);
        chk("ret0_nextx", int'(PC_NEXTX), 3);
        tick(7'b0100000);
        chk("take1_nextx", int'(PC_NEXTX), 2);
        chk("take1_ld1", int'(PC_LD_INT1X), 1);
        tick(7'b0000000);
        chk("take1_level", int'(INT_LEVEL), 1);
        // INT0 preempts INT1
        tick(7'b0000010);
        idle3();
        tick(7'b0100000);
        chk("nest_nextx", int'(PC_NEXTX), 1);
        tick(7'b0000000);
        chk("nest_level", int'(INT_LEVEL), 3);
        tick(7'b0000100);
        tick(7'b0100000);
        chk("unnest_nextx", int'(PC_NEXTX), 3);
        tick(7'b0000000);
        chk("unnest_level", int'(INT_LEVEL), 1);
        // return beats a pending INT1 at the same FETCH
        tick(7'b0000001);
        idle3();
        tick(7'b0000100);
        tick(7'b0100000);
        chk("retwin_nextx", int'(PC_NEXTX), 4);
        chk("retwin_ld1", int'(PC_LD_INT1X), 0);
        tick(7'b0100000);
        chk("retwin_take1", int'(PC_NEXTX), 2);
        tick(7'b0000100);
        tick(7'b0100000);
        chk("ret1_nextx", int'(PC_NEXTX), 4);
        // EI with DI: DI wins; RETI in IDLE is ignored
        tick(7'b0011000);
        tick(7'b0000000);
        chk("eidi_ie", int'(IE), 0);
        tick(7'b0000100);
        tick(7'b0100000);
        chk("reti_idle_nextx", int'(PC_NEXTX), 0);
        tick(7'b0000000);
        chk("reti_idle_level", int'(INT_LEVEL), 0);
        // reset in L01 with both requests pending
        tick(7'b0010000);
        tick(7'b0000001);
        idle3();
        tick(7'b0100000);
        tick(7'b0000010);
        idle3();
        tick(7'b0100000);
        tick(7'b0000011);
        idle3();
        chk("pre_rst_level", int'(INT_LEVEL), 3);
        chk("pre_rst_p0", int'(INT0_PENDING), 1);
        chk("pre_rst_p1", int'(INT1_PENDING), 1);
        tick(7'b1000000);
        tick(7'b0100000);
        chk("post_rst_level", int'(INT_LEVEL), 0);
        chk("post_rst_p0", int'(INT0_PENDING), 0);
        chk("post_rst_p1", int'(INT1_PENDING), 0);
        chk("post_rst_ie", int'(IE), 0);
        chk("post_rst_nextx", int'(PC_NEXTX), 0);
        // randomized traffic, checked every cycle by the model
        repeat (4000) begin
            if ($urandom_range(5) == 0) ra = ~ra;
            if ($urandom_range(5) == 0) rb = ~rb;
            v[6] = ($urandom_range(399) == 0);
            v[5] = ($urandom_range(2) == 0);
            v[4] = ($urandom_range(7) == 0);
            v[3] = ($urandom_range(15) == 0);
            v[2] = ($urandom_range(9) == 0);
            v[1] = ra;
            v[0] = rb;
            tick(v);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
